// File: rtl/lzc_norm_pkg.sv
// Shared types and constants for the lzc_norm_seq normalization sequencer.
// Holds the FSM state enum, the chunk width and the chunk-count helper.
package lzc_norm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } state_t;

  localparam int CHUNK_W = 16;

  function automatic int chunks(input int width);
    return width / CHUNK_W;
  endfunction

endpackage

// File: rtl/lzc_norm_seq_if.sv
// Operand/result handshake bundle for lzc_norm_seq.
// slave is the sequencer side, master is the producer/consumer side.
interface lzc_norm_seq_if #(
  parameter int WIDTH = 48,
  parameter int EXP_W = 8,
  parameter int LZC_W = $clog2(WIDTH + 1)
);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_mant;
  logic [EXP_W-1:0] i_exp;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_mant;
  logic [EXP_W-1:0] o_exp;
  logic [LZC_W-1:0] o_lzc;
  logic             o_zero;
  logic             o_underflow;

  modport master (
    output i_valid,
    output i_mant,
    output i_exp,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_mant,
    input  o_exp,
    input  o_lzc,
    input  o_zero,
    input  o_underflow
  );

  modport slave (
    input  i_valid,
    input  i_mant,
    input  i_exp,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_mant,
    output o_exp,
    output o_lzc,
    output o_zero,
    output o_underflow
  );

endinterface

// File: rtl/lzc_norm_seq_lzc16.sv
// Combinational 16-bit leading-zero counter, result 0..16.
// Shared by the sequencer across all mantissa chunks.
module lzc16 (
  input  logic [15:0] d,
  output logic [4:0]  cnt
);

  // Scan LSB to MSB so the highest set bit writes last and wins.
  always_comb begin
    cnt = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (d[i]) cnt = 5'(15 - i);
    end
  end

endmodule

// File: rtl/lzc_norm_seq.sv
// Multi-cycle mantissa normalizer: one 16-bit chunk scanned per cycle.
// Build with LZC_NORM_SUBNORMAL_EN to emit subnormals instead of flushing.
module lzc_norm_seq #(
  parameter int WIDTH = 48,
  parameter int EXP_W = 8,
  parameter int LZC_W = $clog2(WIDTH + 1)
) (
  input logic            i_clk,
  input logic            i_rst,
  lzc_norm_seq_if.slave  bus
);

  import lzc_norm_pkg::*;

  localparam int CHUNKS = chunks(WIDTH);
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int CMP_W  = (LZC_W > EXP_W + 1) ? LZC_W : EXP_W + 1;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] mant;
  logic [EXP_W-1:0] exp_q;
  logic [LZC_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  logic [CHUNK_W-1:0] chunk;
  logic [4:0]         chunk_lzc;
  logic               chunk_nz;

  logic [CMP_W-1:0] lzc_ext;
  logic [CMP_W-1:0] exp_ext;
  logic             is_zero;
  logic             uf;

  logic [WIDTH-1:0] res_mant;
  logic [EXP_W-1:0] res_exp;
  logic             res_uf;

  logic             ready;
  logic             valid;

  logic [WIDTH-1:0] o_mant_q;
  logic [EXP_W-1:0] o_exp_q;
  logic [LZC_W-1:0] o_lzc_q;
  logic             o_zero_q;
  logic             o_uf_q;

  assign chunk    = mant[int'(idx) * CHUNK_W +: CHUNK_W];
  assign chunk_nz = |chunk;

  lzc16 u_lzc16 (
    .d   (chunk),
    .cnt (chunk_lzc)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    valid    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.i_valid) state_nx = SCAN;
      end
      SCAN: begin
        if (chunk_nz || idx == '0) state_nx = SHIFT;
      end
      SHIFT: begin
        state_nx = DONE;
      end
      DONE: begin
        valid = 1'b1;
        if (bus.i_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign lzc_ext = CMP_W'(cnt);
  assign exp_ext = CMP_W'(exp_q);
  assign is_zero = (cnt == LZC_W'(WIDTH));
  assign uf      = (lzc_ext >= exp_ext);

`ifdef LZC_NORM_SUBNORMAL_EN
  logic [EXP_W-1:0] sub_sh;
  assign sub_sh = (exp_q == '0) ? '0 : exp_q - 1'b1;
`endif

  // Shift and exponent adjust from the final count.
  always_comb begin
    res_mant = '0;
    res_exp  = '0;
    res_uf   = 1'b0;
    if (!is_zero && !uf) begin
      res_mant = mant << cnt;
      res_exp  = EXP_W'(exp_ext - lzc_ext);
    end else if (!is_zero) begin
      res_uf = 1'b1;
`ifdef LZC_NORM_SUBNORMAL_EN
      res_mant = mant << sub_sh;
`endif
    end
  end

  // Operand capture, chunk scan accumulation and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mant     <= '0;
      exp_q    <= '0;
      cnt      <= '0;
      idx      <= '0;
      o_mant_q <= '0;
      o_exp_q  <= '0;
      o_lzc_q  <= '0;
      o_zero_q <= 1'b0;
      o_uf_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_valid) begin
            mant  <= bus.i_mant;
            exp_q <= bus.i_exp;
            cnt   <= '0;
            idx   <= IDX_W'(CHUNKS - 1);
          end
        end
        SCAN: begin
          if (chunk_nz) begin
            cnt <= cnt + LZC_W'(chunk_lzc);
          end else begin
            cnt <= cnt + LZC_W'(CHUNK_W);
            if (idx != '0) idx <= idx - 1'b1;
          end
        end
        SHIFT: begin
          o_mant_q <= res_mant;
          o_exp_q  <= res_exp;
          o_lzc_q  <= cnt;
          o_zero_q <= is_zero;
          o_uf_q   <= res_uf;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_valid     = valid;
  assign bus.o_mant      = o_mant_q;
  assign bus.o_exp       = o_exp_q;
  assign bus.o_lzc       = o_lzc_q;
  assign bus.o_zero      = o_zero_q;
  assign bus.o_underflow = o_uf_q;

endmodule

// File: doc/lzc_norm_seq.md
# lzc_norm_seq

Multi-cycle normalization sequencer for the FPU datapath. It accepts a wide, unnormalized mantissa and biased exponent, and scans the mantissa one 16-bit chunk per cycle through a shared 16-bit leading-zero counter. It then left-shifts the mantissa and adjusts the exponent, and returns the result over a valid/ready handshake. It sits between the FPU add/multiply core and the rounding stage.

## Interface
- WIDTH, 48: mantissa width; must be a multiple of 16.
- EXP_W, 8: biased exponent width.
- LZC_W, $clog2(WIDTH+1): width of the leading-zero count.

- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset; asynchronous and active-high.
- i_valid  input  1  input operand valid.
- o_ready  output  1  block can accept an operand.
- i_mant  input  WIDTH  unnormalized mantissa.
- i_exp  input  EXP_W  biased exponent.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_mant  output  WIDTH  normalized mantissa.
- o_exp  output  EXP_W  adjusted exponent.
- o_lzc  output  LZC_W  total leading zeros of i_mant.
- o_zero  output  1  i_mant was all zero.
- o_underflow  output  1  lzc ≥ i_exp; the exponent was clamped.

## Operation
- FSM has four states: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - o_ready = 1.
  - On i_valid, capture i_mant and i_exp, clear the count, set chunk index = CHUNKS-1 (MSB chunk), and go to SCAN.
- SCAN, one chunk per cycle:
  - The chunk goes to lzc16.
  - If the chunk is nonzero: count += chunk lzc, then go to SHIFT.
  - If the chunk is zero: count += 16, then decrement the index. At index 0, go to SHIFT.
- SHIFT, one cycle, with count = lzc:
  - All-zero mantissa: o_zero = 1, o_mant = 0, o_exp = 0, o_lzc = WIDTH, o_underflow = 0.
  - If lzc < i_exp: o_mant = mant << lzc, o_exp = i_exp − lzc.
  - Otherwise, the underflow case applies (see Configuration).
  - Go to DONE.
- DONE:
  - o_valid = 1 and all outputs are held stable.
  - On i_ready, go to IDLE.
- o_ready is 1 only in IDLE. i_valid is ignored in every other state, so there is no accept in the same cycle as a DONE handshake.
- Exponent arithmetic is unsigned at EXP_W+1 bits. o_lzc saturates at WIDTH.

## Timing
- Let k = number of chunks scanned: the position of the first nonzero chunk from the MSB, or CHUNKS if the mantissa is zero.
- Latency: o_valid rises k+2 cycles after the input handshake cycle.
- Throughput: one operand per k+3 cycles, at minimum.
- Reset values: o_ready = 1 after reset is released; o_valid, o_mant, o_exp, o_lzc, o_zero and o_underflow are all 0. The FSM is in IDLE.
- Reset asserted in any state clears the FSM and outputs immediately. Any in-flight operand is dropped.
- Backpressure: while i_ready = 0 in DONE, all outputs must hold stable.

## Configuration
- LZC_NORM_SUBNORMAL_EN, defined: the underflow case produces a subnormal result.
  - Shift by max(i_exp, 1) − 1.
  - o_exp = 0, o_underflow = 1.
  - o_lzc still reports the true count.
- LZC_NORM_SUBNORMAL_EN, undefined: the underflow case flushes to zero.
  - o_mant = 0, o_exp = 0, o_underflow = 1.

## Structure
- Package lzc_norm_pkg holds:
  - the state enum (IDLE, SCAN, SHIFT, DONE);
  - the CHUNK_W = 16 constant;
  - the CHUNKS = WIDTH/CHUNK_W helper function.
- Sub-module lzc16: a combinational 16-bit leading-zero counter with output range 0..16. It has exactly one instance, time-shared across chunks by the FSM.
- The shifter and exponent adjust are inline combinational logic, registered on entry to DONE.

## Test plan
All cases use WIDTH = 48 and EXP_W = 8.
- i_mant = 48'h8000_0000_0000, i_exp = 100:
  - o_valid 3 cycles after handshake.
  - o_lzc = 0, o_exp = 100, o_mant unchanged.
- i_mant = 48'h0000_0001_0000, i_exp = 100:
  - o_valid after 4 cycles.
  - o_lzc = 31, o_exp = 69, o_mant = 48'h8000_0000_0000.
- i_mant = 0, i_exp = 50:
  - o_valid after 5 cycles.
  - o_zero = 1, o_lzc = 48, o_mant = 0, o_exp = 0.
- i_mant = 48'h0000_0000_0001, i_exp = 10:
  - With the macro: o_mant = 48'h0000_0000_0200, o_exp = 0, o_underflow = 1, o_lzc = 47.
  - Without the macro: o_mant = 0, o_exp = 0, o_underflow = 1.
- Hold i_ready = 0 for 5 cycles in DONE while pulsing i_valid:
  - Outputs stay stable and o_ready stays 0.
  - The second operand is accepted only after the DONE handshake and a return to IDLE.
- Assert i_rst during SCAN of a 3-chunk operand:
  - o_valid = 0 and o_ready = 1 immediately.
  - The next operand completes with correct results.
